wb_pipe_mem_slave: RTL and testbench
====================================

# wb_pipe_mem_slave

Pipelined Wishbone B4 responder: a word-addressed on-chip memory that services requests from a pipelined Wishbone initiator, such as the Ibex instruction or data port. It accepts one request per cycle and applies byte-lane writes. It returns acks in order after a fixed, parameterised latency. It throttles the initiator with `stall` when its outstanding-request budget is exhausted.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in 32-bit words; power of 2, at least 2.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to 4*DEPTH.
- `LATENCY`, 1: cycles from accept edge to response; range 1..4.
- `MAX_OUTST`, 2: maximum accepted-but-unanswered requests; range 1..LATENCY+1.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_wb_cyc` in 1: bus cycle active.
- `i_wb_stb` in 1: request strobe.
- `i_wb_we` in 1: 1 = write, 0 = read.
- `i_wb_sel` in 4: byte-lane enables; bit n covers data[8n+7:8n].
- `i_wb_adr` in 32: byte address; bits [1:0] are ignored.
- `i_wb_dat` in 32: write data.
- `o_wb_dat` out 32: read data; valid only while `o_wb_ack` is high, 0 otherwise.
- `o_wb_ack` out 1: one-cycle successful response.
- `o_wb_err` out 1: one-cycle error response.
- `o_wb_stall` out 1: request not accepted this cycle.

## Operation
- Accept condition is `cyc & stb & !stall`, sampled on the rising edge. Each accept produces exactly one response, either ack or err, and responses are in order.
- Write: at the accept edge, each byte whose `sel` bit is 1 is written; the other bytes are unchanged. `sel` = 0 still acks and writes nothing.
- Read: memory is read at the accept edge. A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Response pipeline: LATENCY stages, each holding {valid, err, data}. Stages shift every cycle unconditionally.
- Outstanding counter `outst` is 0..MAX_OUTST. It increments on accept and decrements on retire (ack or err). When accept and retire happen in the same cycle, it is unchanged.
- `o_wb_stall = (outst == MAX_OUTST) & !retire_this_cycle`. This is combinational from registered state only; there is no path from any `i_wb_*` input to `stall`.
- Abort: if `i_wb_cyc` is low at an edge, all pipeline valid bits and `outst` clear. In-flight reads are discarded and no ack or err is produced for them. Writes already accepted remain committed.
- `stb` while `cyc` is low is ignored.
- Memory contents are not reset.

## Timing
- Reset: `o_wb_ack`, `o_wb_err`, `o_wb_stall` = 0; `o_wb_dat` = 0; `outst` = 0; all pipeline valid bits = 0. Reset takes effect immediately on assertion, asynchronously.
- The first accept is possible at the first rising edge after `rst_n` deasserts.
- A request accepted at edge N is answered by `ack` or `err` high during the cycle after edge N+LATENCY-1. With LATENCY = 1, the response comes in the cycle immediately after the accept.
- Back-to-back accepts produce back-to-back responses, giving a throughput of 1 per cycle whenever MAX_OUTST > LATENCY-1.
- `ack` and `err` are never both high. Each is high for exactly one cycle per request.
- Reset asserted mid-burst: all state clears immediately, and no response appears after release.

## Configuration
- `WB_MEM_ERR_EN` defined:
  - Addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH) are still accepted, but their response is `err` instead of `ack`.
  - A write to such an address is suppressed; a read returns `o_wb_dat` = 0.
  - The err response has the same latency and ordering as a normal ack.
- `WB_MEM_ERR_EN` undefined:
  - There is no range check. The word index is `i_wb_adr[$clog2(DEPTH)+1:2]`, so addresses alias modulo 4*DEPTH.
  - Every accept produces `ack`, and `o_wb_err` is tied to 0.

## Test plan
- Reset and idle: hold `rst_n` low, then release with cyc = 0 → all outputs are 0 and `stall` stays 0.
- Write then read, LATENCY = 1: write 32'hDEAD_BEEF to 0x10 with sel = 4'hF, then immediately read 0x10 → ack in the cycle after each accept, and the read returns 32'hDEAD_BEEF.
- Byte lanes: with word 0x20 = 32'h1122_3344, write 32'hAABB_CCDD with sel = 4'b0101, then read → 32'h11BB_33DD.
- Stall, LATENCY = 3, MAX_OUTST = 2: stream 6 reads back-to-back → `stall` is high on the 3rd request cycle. The result is that 6 acks arrive in address order and the count of acks equals the count of accepts.
- Abort: accept 2 reads (LATENCY = 3), then drop `cyc` on the next cycle → no ack appears, `outst` = 0, and a new request the following cycle is accepted and acked normally.
- Error, with `WB_MEM_ERR_EN` defined and DEPTH = 1024: read 0x1000 → `err` at the ack timing, data 0. Write 0x1000 followed by read 0x0 → word 0 is unchanged. Without the macro, a read of 0x1000 acks with word 0's contents.

Source files
------------

// File: rtl/wb_pipe_mem_slave_if.sv
// Pipelined Wishbone B4 bus bundle between an initiator and the memory responder.
// Signal names keep the bus direction prefix as seen from the responder.
interface wb_pipe_mem_slave_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_wb_err;
    logic        o_wb_stall;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
        input  o_wb_dat, o_wb_ack, o_wb_err, o_wb_stall
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
        output o_wb_dat, o_wb_ack, o_wb_err, o_wb_stall
    );
endinterface

// File: rtl/wb_pipe_mem_slave.sv
// Pipelined Wishbone B4 word memory with fixed-latency in-order responses.
// Define WB_MEM_ERR_EN to answer out-of-range addresses with err instead of ack.
module wb_pipe_mem_slave #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned MAX_OUTST = 2
) (
    input logic               clk,
    input logic               rst_n,
    wb_pipe_mem_slave_if.slave wb
);
    localparam int unsigned   AW        = $clog2(DEPTH);
    localparam int unsigned   CW        = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] OUTST_MAX = CW'(MAX_OUTST);
    localparam logic [31:0]   SPAN_MASK = 32'(4 * DEPTH - 1);

    logic [31:0]        mem_q [DEPTH];
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [31:0]        dat_q [LATENCY];
    logic [31:0]        dat_d [LATENCY];
    logic [CW-1:0]      outst_q, outst_d;

    logic          accept;
    logic          retire;
    logic          in_range;
    logic          stall;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;

    // BASE_ADDR is aligned to the span, so the offset keeps the aliasing index bits
    assign off = wb.i_wb_adr - BASE_ADDR;
    assign idx = off[AW+1:2];

`ifdef WB_MEM_ERR_EN
    assign in_range = (off & ~SPAN_MASK) == 32'h0;
`else
    assign in_range = 1'b1;
`endif

    assign retire = vld_q[LATENCY-1];
    assign stall  = (outst_q == OUTST_MAX) && !retire;
    assign accept = wb.i_wb_cyc && wb.i_wb_stb && !stall;
    assign rdata  = (!wb.i_wb_we && in_range) ? mem_q[idx] : 32'h0;

    always_comb begin
        vld_d    = vld_q << 1;
        err_d    = err_q << 1;
        vld_d[0] = accept;
        err_d[0] = accept && !in_range;
        dat_d[0] = rdata;
        for (int i = 1; i < int'(LATENCY); i++) begin
            dat_d[i] = dat_q[i-1];
        end
        outst_d = outst_q;
        if (accept && !retire) begin
            outst_d = outst_q + 1'b1;
        end else if (!accept && retire) begin
            outst_d = outst_q - 1'b1;
        end
        // Dropping cyc abandons everything still in flight
        if (!wb.i_wb_cyc) begin
            vld_d   = '0;
            outst_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            err_q   <= '0;
            outst_q <= '0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                dat_q[i] <= 32'h0;
            end
        end else begin
            vld_q   <= vld_d;
            err_q   <= err_d;
            outst_q <= outst_d;
            for (int i = 0; i < int'(LATENCY); i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && wb.i_wb_we && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.i_wb_sel[b]) begin
                    mem_q[idx][8*b +: 8] <= wb.i_wb_dat[8*b +: 8];
                end
            end
        end
    end

    assign wb.o_wb_ack   = retire && !err_q[LATENCY-1];
`ifdef WB_MEM_ERR_EN
    assign wb.o_wb_err   = retire && err_q[LATENCY-1];
`else
    assign wb.o_wb_err   = 1'b0;
`endif
    assign wb.o_wb_dat   = wb.o_wb_ack ? dat_q[LATENCY-1] : 32'h0;
    assign wb.o_wb_stall = stall;
endmodule

// File: tb/tb_wb_pipe_mem_slave.sv
// Directed bench: LATENCY=1 table vectors plus LATENCY=3 stall, abort and reset sequences.
// Expectations follow WB_MEM_ERR_EN when it is defined for the build.
module tb_wb_pipe_mem_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_pipe_mem_slave_if b1();
    wb_pipe_mem_slave_if b3();

    wb_pipe_mem_slave #(.LATENCY(1), .MAX_OUTST(2)) u1 (
        .clk(clk), .rst_n(rst_n), .wb(b1)
    );
    wb_pipe_mem_slave #(.LATENCY(3), .MAX_OUTST(2)) u3 (
        .clk(clk), .rst_n(rst_n), .wb(b3)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        exp_ack;
        logic        exp_err;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic        rd;
        int          cyc;
    } exp_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [3:0] sel,
                       input logic [31:0] adr, input logic [31:0] wdat,
                       input logic ea, input logic ee,
                       input logic cd, input logic [31:0] ed);
        vec_t v;
        v.we = we; v.sel = sel; v.adr = adr; v.wdat = wdat;
        v.exp_ack = ea; v.exp_err = ee; v.chk_dat = cd; v.exp_dat = ed;
        vt.push_back(v);
    endtask

    task automatic idle_b3(input int n);
        b3.i_wb_stb = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic run3(input int n, input logic we, input logic [31:0] base,
                        output int n_acc, output int n_ack,
                        output logic stall3rd);
        exp_t q[$];
        exp_t e;
        int   idx;
        logic st;
        idx = 0; n_acc = 0; n_ack = 0; stall3rd = 1'b0;
        b3.i_wb_cyc = 1'b1;
        for (int c = 0; c < 60 && !(idx == n && q.size() == 0); c++) begin
            @(negedge clk);
            if (idx < n) begin
                b3.i_wb_stb = 1'b1;
                b3.i_wb_we  = we;
                b3.i_wb_sel = 4'hF;
                b3.i_wb_adr = base + 32'(4 * idx);
                b3.i_wb_dat = 32'hA000_0000 + 32'(idx);
            end else begin
                b3.i_wb_stb = 1'b0;
            end
            st = b3.o_wb_stall;
            if (c == 2) stall3rd = st;
            @(posedge clk);
            #1;
            if (idx < n && !st) begin
                e.dat = 32'hA000_0000 + 32'(idx);
                e.rd  = !we;
                e.cyc = c;
                q.push_back(e);
                idx++;
                n_acc++;
            end
            chk("ack_err_excl", {31'b0, b3.o_wb_ack & b3.o_wb_err}, 32'h0);
            if (b3.o_wb_ack || b3.o_wb_err) begin
                if (q.size() == 0) begin
                    chk("spurious_ack", 32'h1, 32'h0);
                end else begin
                    e = q.pop_front();
                    n_ack++;
                    chk("lat3", 32'(c), 32'(e.cyc + 2));
                    if (e.rd) chk("rd3_dat", b3.o_wb_dat, e.dat);
                end
            end
        end
        if (idx != n || q.size() != 0) chk("stream_timeout", 32'(idx), 32'(n));
        b3.i_wb_stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_acc, n_ack, k;
        logic s3;

        b1.i_wb_cyc = 0; b1.i_wb_stb = 0; b1.i_wb_we = 0;
        b1.i_wb_sel = 0; b1.i_wb_adr = 0; b1.i_wb_dat = 0;
        b3.i_wb_cyc = 0; b3.i_wb_stb = 0; b3.i_wb_we = 0;
        b3.i_wb_sel = 0; b3.i_wb_adr = 0; b3.i_wb_dat = 0;

        add(1, 4'hF, 32'h10,  32'hDEAD_BEEF, 1, 0, 0, 32'h0);
        add(0, 4'hF, 32'h10,  32'h0,         1, 0, 1, 32'hDEAD_BEEF);
        add(1, 4'hF, 32'h20,  32'h1122_3344, 1, 0, 0, 32'h0);
        add(1, 4'h5, 32'h20,  32'hAABB_CCDD, 1, 0, 0, 32'h0);
        add(0, 4'hF, 32'h20,  32'h0,         1, 0, 1, 32'h11BB_33DD);
        add(1, 4'hF, 32'h24,  32'h0,         1, 0, 0, 32'h0);
        add(1, 4'h0, 32'h24,  32'hFFFF_FFFF, 1, 0, 0, 32'h0);
        add(0, 4'hF, 32'h24,  32'h0,         1, 0, 1, 32'h0);
        add(1, 4'hF, 32'h0,   32'hCAFE_F00D, 1, 0, 0, 32'h0);
        add(0, 4'hF, 32'h0,   32'h0,         1, 0, 1, 32'hCAFE_F00D);
`ifdef WB_MEM_ERR_EN
        add(0, 4'hF, 32'h1000, 32'h0,         0, 1, 1, 32'h0);
        add(1, 4'hF, 32'h1000, 32'h1234_5678, 0, 1, 0, 32'h0);
        add(0, 4'hF, 32'h0,    32'h0,         1, 0, 1, 32'hCAFE_F00D);
`else
        add(0, 4'hF, 32'h1000, 32'h0,         1, 0, 1, 32'hCAFE_F00D);
        add(1, 4'hF, 32'h1000, 32'h1234_5678, 1, 0, 0, 32'h0);
        add(0, 4'hF, 32'h0,    32'h0,         1, 0, 1, 32'h1234_5678);
`endif
        add(1, 4'hF, 32'hFFC, 32'h0102_0304, 1, 0, 0, 32'h0);
        add(1, 4'h8, 32'hFFC, 32'hAA00_0000, 1, 0, 0, 32'h0);
        add(0, 4'hF, 32'hFFC, 32'h0,         1, 0, 1, 32'hAA02_0304);

        #12;
        chk("rst_ack1",   {31'b0, b1.o_wb_ack},   32'h0);
        chk("rst_err1",   {31'b0, b1.o_wb_err},   32'h0);
        chk("rst_stall1", {31'b0, b1.o_wb_stall}, 32'h0);
        chk("rst_dat1",   b1.o_wb_dat,            32'h0);
        chk("rst_ack3",   {31'b0, b3.o_wb_ack},   32'h0);
        chk("rst_stall3", {31'b0, b3.o_wb_stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_stall1", {31'b0, b1.o_wb_stall}, 32'h0);
            chk("idle_ack1",   {31'b0, b1.o_wb_ack},   32'h0);
            chk("idle_stall3", {31'b0, b3.o_wb_stall}, 32'h0);
        end

        b1.i_wb_cyc = 1'b1;
        foreach (vt[i]) begin
            b1.i_wb_stb = 1'b1;
            b1.i_wb_we  = vt[i].we;
            b1.i_wb_sel = vt[i].sel;
            b1.i_wb_adr = vt[i].adr;
            b1.i_wb_dat = vt[i].wdat;
            chk($sformatf("v%0d_stall", i), {31'b0, b1.o_wb_stall}, 32'h0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ack", i), {31'b0, b1.o_wb_ack}, {31'b0, vt[i].exp_ack});
            chk($sformatf("v%0d_err", i), {31'b0, b1.o_wb_err}, {31'b0, vt[i].exp_err});
            if (vt[i].chk_dat) chk($sformatf("v%0d_dat", i), b1.o_wb_dat, vt[i].exp_dat);
            @(negedge clk);
        end
        b1.i_wb_stb = 1'b0;
        b1.i_wb_cyc = 1'b0;
        @(posedge clk);
        #1;
        chk("v_end_ack", {31'b0, b1.o_wb_ack}, 32'h0);

        run3(6, 1'b1, 32'h40, n_acc, n_ack, s3);
        chk("wr_stream_acks", 32'(n_ack), 32'd6);
        idle_b3(3);
        run3(6, 1'b0, 32'h40, n_acc, n_ack, s3);
        chk("rd_stall_3rd", {31'b0, s3}, 32'h1);
        chk("rd_accepts",   32'(n_acc), 32'd6);
        chk("rd_acks",      32'(n_ack), 32'd6);
        idle_b3(3);

        @(negedge clk);
        b3.i_wb_cyc = 1'b1; b3.i_wb_stb = 1'b1; b3.i_wb_we = 1'b0;
        b3.i_wb_adr = 32'h40;
        @(negedge clk);
        chk("abort_stall", {31'b0, b3.o_wb_stall}, 32'h0);
        b3.i_wb_adr = 32'h44;
        @(negedge clk);
        b3.i_wb_cyc = 1'b0; b3.i_wb_stb = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            chk("abort_noack", {30'b0, b3.o_wb_ack, b3.o_wb_err}, 32'h0);
        end
        @(negedge clk);
        chk("abort_outst", {31'b0, b3.o_wb_stall}, 32'h0);
        b3.i_wb_cyc = 1'b1; b3.i_wb_stb = 1'b1; b3.i_wb_adr = 32'h48;
        @(posedge clk);
        @(negedge clk);
        b3.i_wb_stb = 1'b0;
        k = 5;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            if (b3.o_wb_ack && k == 5) begin
                k = j;
                chk("abort_new_dat", b3.o_wb_dat, 32'hA000_0002);
            end
        end
        chk("abort_new_lat", 32'(k), 32'd1);

        @(negedge clk);
        b3.i_wb_stb = 1'b1; b3.i_wb_adr = 32'h40;
        @(negedge clk);
        b3.i_wb_adr = 32'h44;
        @(negedge clk);
        b3.i_wb_stb = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", {31'b0, b3.o_wb_ack}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ack", {31'b0, b3.o_wb_ack}, 32'h0);
        chk("rst_async_dat", b3.o_wb_dat, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            chk("rst_noack", {30'b0, b3.o_wb_ack, b3.o_wb_err}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
